// File: rtl/pixel_framebuffer_if.sv
// pixel_framebuffer_if -- pixel write / scan-out bundle for pixel_framebuffer.
//   master : drives iPlot/iX/iY/iColour (pixel write), iClear (fill start),
//            iScanEn (scan advance); observes the status and scan outputs.
//   slave  : the framebuffer; drives oBusy, oDropped, oScanX/Y/Colour,
//            oScanValid, oFrameStart.
interface pixel_framebuffer_if;
  logic       iPlot;
  logic [7:0] iX;
  logic [6:0] iY;
  logic [2:0] iColour;
  logic       iClear;
  logic       iScanEn;
  logic       oBusy;
  logic       oDropped;
  logic [7:0] oScanX;
  logic [6:0] oScanY;
  logic [2:0] oScanColour;
  logic       oScanValid;
  logic       oFrameStart;

  modport master (
    output iPlot, iX, iY, iColour, iClear, iScanEn,
    input  oBusy, oDropped, oScanX, oScanY, oScanColour, oScanValid, oFrameStart
  );

  modport slave (
    input  iPlot, iX, iY, iColour, iClear, iScanEn,
    output oBusy, oDropped, oScanX, oScanY, oScanColour, oScanValid, oFrameStart
  );
endinterface

// File: rtl/pixel_framebuffer.sv
// pixel_framebuffer -- 3-bit-per-pixel framebuffer with a one-pixel-per-cycle
// write port, a whole-buffer clear engine and a raster scan-out port.
//   iClock : single clock, rising edge
//   iReset : asynchronous, active-high reset (storage itself is not reset)
//   bus    : pixel_framebuffer_if.slave
//     iPlot/iX/iY/iColour : pixel write, accepted only when idle and in range
//     iClear              : start filling every word with 3'b000
//     iScanEn             : advance the raster counters this cycle
//     oBusy               : clear in progress
//     oDropped            : one-cycle pulse after a rejected write
//     oScan*              : registered read of the previous cycle's raster
//                           position (1-cycle latency)
//     oFrameStart         : pulse together with the pixel (0,0)
module pixel_framebuffer #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int H_BLANK         = 40,
  parameter int V_BLANK         = 5
) (
  input logic iClock,
  input logic iReset,
  pixel_framebuffer_if.slave bus
);

  localparam int NWORDS  = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int H_TOTAL = X_SCREEN_PIXELS + H_BLANK;
  localparam int V_TOTAL = Y_SCREEN_PIXELS + V_BLANK;
  localparam logic [14:0] LAST_ADDR = 15'(NWORDS - 1);
  localparam logic [14:0] X_W       = 15'(X_SCREEN_PIXELS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state;
  logic [14:0] clrAddr;
  logic        busy;
  logic        dropped;

  logic [7:0]  hCount;
  logic [6:0]  vCount;
  logic [7:0]  scanX;
  logic [6:0]  scanY;
  logic [2:0]  scanColour;
  logic        scanValid;
  logic        frameStart;

  logic [2:0]  mem [NWORDS];

  // Write side decode. A clear request in the same cycle takes priority and
  // the write is rejected.
  logic        inRange;
  logic        plotOk;
  logic [14:0] plotAddr;

  assign inRange  = (int'(bus.iX) < X_SCREEN_PIXELS) && (int'(bus.iY) < Y_SCREEN_PIXELS);
  assign plotOk   = bus.iPlot && (state == IDLE) && !bus.iClear && inRange && !iReset;
  assign plotAddr = 15'(bus.iY) * X_W + 15'(bus.iX);

  // Scan side decode
  logic        scanVis;
  logic [14:0] scanAddr;

  assign scanVis  = (int'(hCount) < X_SCREEN_PIXELS) && (int'(vCount) < Y_SCREEN_PIXELS);
  assign scanAddr = scanVis ? (15'(vCount) * X_W + 15'(hCount)) : 15'd0;

  // Storage: no reset so contents survive iReset. Clear owns the port while
  // active; plot writes only land when idle.
  always_ff @(posedge iClock) begin
    if (state == CLEAR && !iReset)
      mem[clrAddr] <= 3'b000;
    else if (plotOk)
      mem[plotAddr] <= bus.iColour;
  end

  // Control FSM: clear walks addresses 0..NWORDS-1 once, one per cycle.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state   <= IDLE;
      clrAddr <= '0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      dropped <= bus.iPlot && !((state == IDLE) && !bus.iClear && inRange);
      case (state)
        IDLE: begin
          if (bus.iClear) begin
            state   <= CLEAR;
            clrAddr <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          clrAddr <= clrAddr + 15'd1;
          if (clrAddr == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Raster counters and registered scan read. The memory read samples the
  // word before any same-edge write, so a collision returns the old colour.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      hCount     <= '0;
      vCount     <= '0;
      scanX      <= '0;
      scanY      <= '0;
      scanColour <= '0;
      scanValid  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      scanX <= hCount;
      scanY <= vCount;
      if (bus.iScanEn) begin
        scanValid  <= scanVis;
        frameStart <= scanVis && (hCount == '0) && (vCount == '0);
        scanColour <= scanVis ? mem[scanAddr] : 3'b000;
        if (int'(hCount) == H_TOTAL - 1) begin
          hCount <= '0;
          if (int'(vCount) == V_TOTAL - 1) vCount <= '0;
          else                             vCount <= vCount + 7'd1;
        end else begin
          hCount <= hCount + 8'd1;
        end
      end else begin
        scanValid  <= 1'b0;
        frameStart <= 1'b0;
        scanColour <= 3'b000;
      end
    end
  end

  assign bus.oBusy       = busy;
  assign bus.oDropped    = dropped;
  assign bus.oScanX      = scanX;
  assign bus.oScanY      = scanY;
  assign bus.oScanColour = scanColour;
  assign bus.oScanValid  = scanValid;
  assign bus.oFrameStart = frameStart;

endmodule

// File: tb/tb_pixel_framebuffer.sv
module tb_pixel_framebuffer;
  localparam int XP = 160, YP = 120, HT = 200, VT = 125;
  localparam int NW = XP * YP;      // 19200
  localparam int FRAME = HT * VT;   // 25000

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_framebuffer_if bus();

  pixel_framebuffer #(.X_SCREEN_PIXELS(XP), .Y_SCREEN_PIXELS(YP), .H_BLANK(40), .V_BLANK(5))
    dut (.iClock(clk), .iReset(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pixel store (-1 = never written, contents unknown), a clear countdown and
  // a linear count of enabled scan reads; raster position is derived from it.
  int mdl [NW];
  bit busyM = 0;
  int clrIdx = 0;
  int scanN = 0;
  bit eBusy = 0, eDrop = 0, eValid = 0, eFS = 0;
  int eCol = 0, eX = 0, eY = 0;
  bit mInR;
  int mPos, mH, mV;

  initial foreach (mdl[i]) mdl[i] = -1;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      busyM = 0; clrIdx = 0; scanN = 0;
      eBusy = 0; eDrop = 0; eValid = 0; eFS = 0; eCol = 0; eX = 0; eY = 0;
    end else begin
      mInR = (bus.iX < XP) && (bus.iY < YP);
      eDrop = bus.iPlot && (busyM || bus.iClear || !mInR);
      if (bus.iScanEn) begin
        mPos = scanN % FRAME;
        mH = mPos % HT;
        mV = mPos / HT;
        eValid = (mH < XP) && (mV < YP);
        eX = mH; eY = mV;
        eFS = (mPos == 0);
        eCol = eValid ? mdl[mV * XP + mH] : 0;
        scanN++;
      end else begin
        eValid = 0; eFS = 0; eCol = 0;
      end
      if (busyM) begin
        mdl[clrIdx] = 0;
        clrIdx++;
        if (clrIdx == NW) busyM = 0;
      end else if (bus.iClear) begin
        busyM = 1; clrIdx = 0;
      end else if (bus.iPlot && mInR) begin
        mdl[bus.iY * XP + bus.iX] = bus.iColour;
      end
      eBusy = busyM;
    end
  end

  // ---------------- compare process ----------------
  bit armed = 0;
  int cyc = 0, lastFs = 0, fsPeriod = 0;
  int validCnt = 0, validPrev = 0, nzCnt = 0, nzPrev = 0;
  int seen [NW];

  initial foreach (seen[i]) seen[i] = -1;

  initial forever begin
    @(negedge clk);
    if (armed) begin
      cyc++;
      check("busy", bus.oBusy, eBusy);
      check("dropped", bus.oDropped, eDrop);
      check("valid", bus.oScanValid, eValid);
      check("framestart", bus.oFrameStart, eFS);
      if (!eValid) check("colour_blank", bus.oScanColour, 0);
      else begin
        check("scanx", bus.oScanX, eX);
        check("scany", bus.oScanY, eY);
        if (eCol >= 0) check("colour", bus.oScanColour, eCol);
      end
      if (bus.oFrameStart) begin
        fsPeriod = cyc - lastFs; lastFs = cyc;
        validPrev = validCnt; nzPrev = nzCnt; validCnt = 0; nzCnt = 0;
      end
      if (bus.oScanValid) begin
        validCnt++;
        if (bus.oScanColour != 0) nzCnt++;
        if (bus.oScanX < XP && bus.oScanY < YP)
          seen[bus.oScanY * XP + bus.oScanX] = bus.oScanColour;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic setIn(input bit p, input int x, input int y, input int c, input bit clr, input bit en);
    bus.iPlot = p; bus.iX = 8'(x); bus.iY = 7'(y); bus.iColour = 3'(c);
    bus.iClear = clr; bus.iScanEn = en;
  endtask

  task automatic randPlot(input bit en);
    setIn($urandom_range(0, 1) == 1, $urandom_range(0, 170), $urandom_range(0, 125),
          $urandom_range(0, 7), 0, en);
  endtask

  int busyCnt;
  int guard;

  initial begin
    rst = 1'b1;
    setIn(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    armed = 1;
    // reset state
    check("rst_busy", bus.oBusy, 0);
    check("rst_dropped", bus.oDropped, 0);
    check("rst_valid", bus.oScanValid, 0);
    check("rst_fs", bus.oFrameStart, 0);
    check("rst_colour", bus.oScanColour, 0);
    check("rst_x", bus.oScanX, 0);
    check("rst_y", bus.oScanY, 0);
    rst = 1'b0;

    // clear with a colliding plot (clear wins), scanning from the start
    setIn(1, 5, 5, 1, 1, 1);
    tick();
    busyCnt = 0;
    for (guard = 0; guard < 20000; guard++) begin
      if (!bus.oBusy) break;
      busyCnt++;
      setIn($urandom_range(0, 1) == 1, $urandom_range(0, 170), $urandom_range(0, 125),
            $urandom_range(0, 7), $urandom_range(0, 9) == 0, 1);
      tick();
    end
    setIn(0, 0, 0, 0, 0, 1);
    check("clear_busy_cycles", busyCnt, 19200);

    // known pixels, then out-of-range drops
    setIn(1, 0, 0, 5, 0, 1);    tick();
    setIn(1, 159, 119, 3, 0, 1); tick();
    setIn(1, 37, 64, 6, 0, 1);  tick();
    setIn(1, 160, 5, 7, 0, 1);  tick();
    setIn(0, 0, 0, 0, 0, 1);
    check("drop_x_pulse", bus.oDropped, 1);
    tick();
    check("drop_x_end", bus.oDropped, 0);
    setIn(1, 3, 120, 7, 0, 1);  tick();
    setIn(0, 0, 0, 0, 0, 1);
    check("drop_y_pulse", bus.oDropped, 1);
    tick();
    check("drop_y_end", bus.oDropped, 0);

    // frame F1 start
    for (guard = 0; guard < 26000 && !bus.oFrameStart; guard++) tick();
    check("wait_f1", bus.oFrameStart, 1);
    // write (10,10) in the very cycle the scan reads it
    for (guard = 0; guard < 3000 && (scanN % FRAME) != 10 * HT + 10; guard++) tick();
    check("wait_collide", scanN % FRAME, 10 * HT + 10);
    setIn(1, 10, 10, 7, 0, 1); tick();
    setIn(0, 0, 0, 0, 0, 1);
    tick();
    for (guard = 0; guard < 26000 && !bus.oFrameStart; guard++) tick();
    check("wait_f2", bus.oFrameStart, 1);
    check("fs_period", fsPeriod, FRAME);
    check("valid_per_frame", validPrev, NW);
    check("nonzero_per_frame", nzPrev, 3);
    check("px_0_0", seen[0], 5);
    check("px_159_119", seen[119 * XP + 159], 3);
    check("px_37_64", seen[64 * XP + 37], 6);
    check("px_10_10_old", seen[10 * XP + 10], 0);
    for (guard = 0; guard < 3000 && (scanN % FRAME) <= 10 * HT + 10; guard++) tick();
    check("px_10_10_new", seen[10 * XP + 10], 7);

    // random plots with intermittent scan enable
    for (int i = 0; i < 4000; i++) begin
      randPlot($urandom_range(0, 4) != 0);
      tick();
    end

    // reset part-way through a clear
    setIn(1, 0, 0, 5, 0, 1);   tick();
    setIn(1, 40, 40, 3, 0, 1); tick();
    setIn(0, 0, 0, 0, 1, 1);   tick();
    setIn(0, 0, 0, 0, 0, 1);
    busyCnt = 0;
    for (guard = 0; guard < 6000 && busyCnt < 5000; guard++) begin
      if (bus.oBusy) busyCnt++;
      if (busyCnt < 5000) begin
        randPlot(1);
        tick();
      end
    end
    setIn(0, 0, 0, 0, 0, 1);
    #1 rst = 1'b1;
    #1;
    check("midclear_rst_busy", bus.oBusy, 0);
    check("midclear_rst_valid", bus.oScanValid, 0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 41 * HT + 20; i++) tick();
    check("after_rst_0_0", seen[0], 0);
    check("after_rst_40_40", seen[40 * XP + 40], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
